fpga_transmitter: RTL and testbench

FPGA_TRANSMITTER -- requirements
Module: fpga_transmitter

---
 rtl/fpga_transmitter.sv | 162 ++++++++++++++++
 tb/tb_fpga_transmitter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_transmitter.sv
// Serial word transmitter to a receiver FPGA over a send/finish/acknowledge handshake, MSB first.
// Optional acknowledge-wait timeout is built in when FPGA_TX_TIMEOUT_EN is defined.
module fpga_transmitter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             send,
    output logic             finish,
    output logic             data_out,
    input  logic             acknowledge
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WSTART,
        BIT,
        WBIT,
        FIN,
        WEND,
        DONE
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    count_inc;
    logic             ack_meta_q, ack_sync_q, ack_prev_q;
    logic             ack_evt;
    logic             expired;

    // Two flops resynchronise the asynchronous acknowledge; a third keeps the
    // previous synchronised value so only its rising edge counts as an event.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
            ack_prev_q <= 1'b0;
        end else begin
            ack_meta_q <= acknowledge;
            ack_sync_q <= ack_meta_q;
            ack_prev_q <= ack_sync_q;
        end
    end

    assign ack_evt   = ack_sync_q & ~ack_prev_q;
    assign count_inc = count_q + CW'(1);

`ifdef FPGA_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] timer_q, timer_d;
    logic          error_q, error_d;
    logic          in_wait;

    assign in_wait = (state_q == WSTART) || (state_q == WBIT) || (state_q == WEND);
    assign expired = (timer_q == TW'(TIMEOUT - 1));

    // The timer only runs while the FSM stays in one wait state, so any
    // entry into a wait state starts it from zero.
    always_comb begin
        timer_d = '0;
        error_d = 1'b0;
        if (in_wait && (state_d == state_q)) begin
            timer_d = timer_q + TW'(1);
        end
        if (in_wait && !ack_evt && expired) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
            error_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT;
    assign expired        = 1'b0;
    assign error          = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = START;
                    shift_d = data_in;
                    count_d = '0;
                end
            end
            START: state_d = WSTART;
            WSTART: begin
                if (ack_evt) begin
                    state_d = BIT;
                end else if (expired) begin
                    state_d = IDLE;
                end
            end
            BIT: state_d = WBIT;
            WBIT: begin
                if (ack_evt) begin
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    count_d = count_inc;
                    state_d = (count_inc == CW'(WIDTH)) ? FIN : BIT;
                end else if (expired) begin
                    state_d = IDLE;
                end
            end
            FIN: state_d = WEND;
            WEND: begin
                if (ack_evt) begin
                    state_d = DONE;
                end else if (expired) begin
                    state_d = IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    // Outputs decode straight from registered state so reset clears them at once.
    assign busy     = (state_q != IDLE);
    assign send     = (state_q == START) || (state_q == BIT);
    assign finish   = (state_q == FIN);
    assign done     = (state_q == DONE);
    assign data_out = ((state_q == BIT) || (state_q == WBIT)) && shift_q[WIDTH-1];

endmodule

// File: tb/tb_fpga_transmitter.sv
// Randomised and directed bench for fpga_transmitter against an event-sequence model of one word.
module tb_fpga_transmitter;

    localparam int W  = 8;
    localparam int TO = 16;

    logic         clock    = 1'b0;
    logic         reset    = 1'b0;
    logic [W-1:0] data_in  = '0;
    logic         load     = 1'b0;
    logic         busy, done, error, send, finish, data_out;
    logic         acknowledge;
    logic         rx_ack   = 1'b0;
    logic         spur_ack = 1'b0;

    int  tests = 0;
    int  fails = 0;
    bit  rx_en = 1'b1;
    int  rx_delay = 3;

    // model: expected events of the word in flight, encoded kind*2+bit
    // kind 0 start send, 1 data send, 2 finish, 3 done
    int  q[$];
    bit  in_flight = 1'b0;
    int  word_dsent = 0;
    int  n_send = 0, n_fin = 0, n_done = 0, n_err = 0;
    int  cyc = 0, last_send_cyc = 0, err_cyc = 0;
    logic [15:0] cap = '0;

    assign acknowledge = rx_ack | spur_ack;

    always #5 clock = ~clock;

    fpga_transmitter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clock       (clock),
        .reset       (reset),
        .data_in     (data_in),
        .load        (load),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .send        (send),
        .finish      (finish),
        .data_out    (data_out),
        .acknowledge (acknowledge)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] kind_pattern(input int kind);
        case (kind)
            0, 1:    return 3'b100;
            2:       return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    task automatic monitor();
        int   ev;
        bit   idle_now;
        int   quiet = 0;
        bit   last_d_valid = 1'b0;
        logic last_d = 1'b0;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset) begin
                chk("reset_outputs", {26'd0, busy, done, error, send, finish, data_out}, 32'd0);
                q.delete();
                in_flight    = 1'b0;
                last_d_valid = 1'b0;
                quiet        = 0;
                continue;
            end
            if (send) begin
                n_send++;
                last_send_cyc = cyc;
                cap = {cap[14:0], data_out};
            end
            if (finish) n_fin++;
            if (done) n_done++;
            if (error) begin
                n_err++;
                err_cyc = cyc;
            end
            idle_now = !in_flight;
`ifdef FPGA_TX_TIMEOUT_EN
            if (error) begin
                chk("error_only_without_ack", {31'd0, rx_en}, 32'd0);
                q.delete();
                in_flight    = 1'b0;
                last_d_valid = 1'b0;
                idle_now     = 1'b1;
            end
`else
            chk("error_tied_low", {31'd0, error}, 32'd0);
`endif
            chk("busy", {31'd0, busy}, {31'd0, in_flight});
            chk("send_finish_exclusive", {31'd0, send & finish}, 32'd0);
            if (send | finish | done) begin
                quiet = 0;
                if (q.size() == 0) begin
                    chk("unexpected_output", {29'd0, send, finish, done}, 32'd0);
                end else begin
                    ev = q.pop_front();
                    chk("output_kind", {29'd0, send, finish, done}, {29'd0, kind_pattern(ev >> 1)});
                    if ((ev >> 1) == 1) begin
                        chk("data_bit", {31'd0, data_out}, ev & 1);
                        word_dsent++;
                    end
                    last_d_valid = ((ev >> 1) == 1);
                    last_d       = ev[0];
                    if ((ev >> 1) == 3) in_flight = 1'b0;
                end
            end else begin
                if (last_d_valid) chk("data_hold", {31'd0, data_out}, {31'd0, last_d});
                if (in_flight && rx_en) begin
                    quiet++;
                    if (quiet > 300) begin
                        chk("progress_timeout", quiet, 0);
                        q.delete();
                        in_flight = 1'b0;
                        quiet     = 0;
                    end
                end
            end
            if (idle_now && load) begin
                in_flight  = 1'b1;
                word_dsent = 0;
                q.push_back(0);
                for (int i = W - 1; i >= 0; i--) q.push_back(2 + int'(data_in[i]));
                q.push_back(4);
                q.push_back(6);
            end
        end
    endtask

    // Receiver FPGA: raise acknowledge rx_delay cycles after each request, hold two cycles.
    task automatic receiver();
        int wait_c = 0;
        int hold   = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                wait_c = 0;
                hold   = 0;
                rx_ack = 1'b0;
                continue;
            end
            if (hold > 0) begin
                hold--;
                if (hold == 0) rx_ack = 1'b0;
            end
            if (wait_c > 0) begin
                wait_c--;
                if (wait_c == 0) begin
                    rx_ack = 1'b1;
                    hold   = 2;
                end
            end
            if ((send | finish) && rx_en) wait_c = rx_delay;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic pulse_load(input logic [W-1:0] d);
        data_in = d;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    // Returns at negedge+1 of the cycle in which done count reaches target.
    task automatic wait_done(input int target, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clock);
            #1;
            if (n_done >= target) break;
        end
        if (k >= budget) chk("wait_done_timeout", n_done, target);
    endtask

    task automatic word_checks(input string name, input int s0, input int f0, input int d0,
                               input logic [7:0] exp_bits);
        chk({name, "_send_pulses"}, n_send - s0, 9);
        chk({name, "_finish_pulses"}, n_fin - f0, 1);
        chk({name, "_done_pulses"}, n_done - d0, 1);
        chk({name, "_bit_sequence"}, {24'd0, cap[7:0]}, {24'd0, exp_bits});
    endtask

    initial begin
        int s0, f0, d0, e0, k;
        fork
            monitor();
            receiver();
        join_none

        repeat (3) @(negedge clock);
        #1;
        chk("reset_state", {26'd0, busy, done, error, send, finish, data_out}, 32'd0);
        #1 reset = 1'b1;
        tick();
        repeat (4) tick();

        // spurious acknowledge while idle
        s0 = n_send;
        spur_ack = 1'b1;
        tick();
        spur_ack = 1'b0;
        repeat (8) tick();
        chk("idle_spurious_send_count", n_send - s0, 0);
        chk("idle_spurious_busy", {31'd0, busy}, 32'd0);

        // A5 with a spurious acknowledge edge landing in START
        s0 = n_send; f0 = n_fin; d0 = n_done;
        spur_ack = 1'b1;
        tick();
        spur_ack = 1'b0;
        pulse_load(8'hA5);
        wait_done(d0 + 1, 400);
        word_checks("A5", s0, f0, d0, 8'b1010_0101);
        tick();
        chk("A5_busy_low_after", {31'd0, busy}, 32'd0);

        // back-to-back 3C in the cycle after done, with an ignored mid-word load
        s0 = n_send; f0 = n_fin; d0 = n_done;
        pulse_load(8'h3C);
        repeat (6) tick();
        pulse_load(8'h81);
        wait_done(d0 + 1, 400);
        word_checks("3C", s0, f0, d0, 8'h3C);
        repeat (20) tick();
        chk("3C_no_extra_sends", n_send - s0, 9);

        // asynchronous reset in the wait after data bit 4
        pulse_load(8'h69);
        for (k = 0; k < 400; k++) begin
            @(negedge clock);
            #1;
            if (word_dsent >= 5) break;
        end
        chk("reach_bit4", {31'd0, k < 400}, 32'd1);
        @(negedge clock);
        d0 = n_done;
        #2 reset = 1'b0;
        #1;
        chk("async_reset_outputs", {26'd0, busy, done, error, send, finish, data_out}, 32'd0);
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        tick();
        repeat (10) tick();
        chk("abort_no_done", n_done - d0, 0);
        s0 = n_send; f0 = n_fin; d0 = n_done;
        pulse_load(8'hFF);
        wait_done(d0 + 1, 400);
        word_checks("FF", s0, f0, d0, 8'hFF);
        tick();

        // randomised loads, data and receiver latency
        d0 = n_done;
        for (int c = 0; c < 3000; c++) begin
            rx_delay = $urandom_range(1, 6);
            data_in  = W'($urandom);
            load     = ($urandom_range(0, 5) == 0);
            tick();
        end
        load = 1'b0;
        for (k = 0; k < 400 && in_flight; k++) tick();
        chk("random_drained", {31'd0, in_flight}, 32'd0);
        chk("random_words_completed", {31'd0, (n_done - d0) > 20}, 32'd1);
        rx_delay = 3;
        repeat (10) tick();

        // receiver never acknowledges
        rx_en = 1'b0;
        d0 = n_done; e0 = n_err;
        pulse_load(8'h5A);
`ifdef FPGA_TX_TIMEOUT_EN
        for (k = 0; k < 80; k++) begin
            @(negedge clock);
            #1;
            if (n_err > e0) break;
        end
        chk("timeout_error_pulses", n_err - e0, 1);
        chk("timeout_latency", err_cyc - last_send_cyc, TO + 1);
        chk("timeout_busy_low", {31'd0, busy}, 32'd0);
        repeat (5) tick();
        chk("timeout_single_pulse", n_err - e0, 1);
        chk("timeout_no_done", n_done - d0, 0);
`else
        repeat (40) tick();
        chk("noack_busy_held", {31'd0, busy}, 32'd1);
        chk("noack_error_low", {31'd0, error}, 32'd0);
        chk("noack_no_done", n_done - d0, 0);
        @(negedge clock);
        #2 reset = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        tick();
`endif
        rx_en = 1'b1;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
